uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side buffer that sits directly downstream of the UART receiver.
//  Captures each received byte together with its 3-bit error code and holds them in
//  a circular FIFO. Software/consumer logic pops entries with a show-ahead read port.
//  Reports overflow and counts discarded erroneous frames.
// PARAMETERS
//  DEPTH     16  number of entries; must be a power of two, >= 2
//  ADDR_W     4  log2(DEPTH)
//  DROP_ERR   0  1: frames with wr_err != 0 are discarded (counted), 0: stored
// PORTS
//  clk        in   1       system clock (50 MHz)
//  reset      in   1       asynchronous, active-low reset
//  wr_en      in   1       one-cycle strobe: new received frame (clk-synchronous)
//  wr_data    in   8       received byte (7-bit mode: bit7 = 0 from upstream)
//  wr_err     in   3       receiver error code for this frame
//  rd_en      in   1       pop request for the head entry
//  rd_data    out  8       head entry data (valid while empty = 0)
//  rd_err     out  3       head entry error code
//  empty      out  1       FIFO holds 0 entries
//  full       out  1       FIFO holds DEPTH entries
//  count      out  ADDR_W+1  number of stored entries, 0..DEPTH
//  overflow   out  1       sticky: a frame was lost because FIFO was full
//  err_cnt    out  8       saturating count of frames dropped by DROP_ERR
//  clr_stat   in   1       one-cycle clear of overflow and err_cnt
// BEHAVIOUR
//  - Reset (reset = 0, async): wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0,
//    overflow = 0, err_cnt = 0; rd_data/rd_err = 0. Memory contents not cleared.
//  - Storage: DEPTH x 11-bit array {err[2:0], data[7:0]}; pointers ADDR_W bits, wrap
//    DEPTH-1 -> 0 naturally; count tracked separately (ADDR_W+1 bits).
//  - Write accept: wr_en & ~drop & (~full | rd_en). drop = DROP_ERR & (wr_err != 0).
//    Accepted entry written at wr_ptr on the rising edge; wr_ptr increments.
//  - Read accept: rd_en & ~empty. rd_ptr increments on the edge; next entry appears
//    on rd_data/rd_err after that edge. rd_en while empty: ignored, no flag.
//  - Show-ahead: rd_data/rd_err = mem[rd_ptr] whenever empty = 0; forced 0 when empty.
//    First written byte is visible the cycle after its write edge (latency 1).
//  - count: +1 on write only, -1 on read only, unchanged on both or neither.
//    empty = (count == 0), full = (count == DEPTH), both derived from registered count.
//  - Simultaneous wr/rd when full: both accepted, count stays DEPTH, no overflow.
//  - Simultaneous wr/rd when empty: write accepted, read ignored, count -> 1.
//  - Overflow: wr_en & ~drop & full & ~rd_en -> frame discarded, overflow <= 1 (sticky).
//  - Drop: wr_en & drop -> not stored regardless of fill; err_cnt += 1, saturates 255.
//  - clr_stat: clears overflow and err_cnt on the edge; if a new overflow/drop event
//    occurs in the same cycle, set wins (overflow = 1, err_cnt = 1).
//  - Reset mid-operation: all contents logically lost (pointers/count zeroed); any
//    wr_en/rd_en in the reset-release cycle is treated normally from the next edge.
//  - Control flow: IDLE/ACTIVE not needed; pointer + count registers form the state.
// TESTING
//  1. Reset, write 0x41,0x42,0x43 (err 0) -> count=3, rd_data=0x41; 3 pops -> 0x41,
//     0x42,0x43 in order, then empty=1, rd_data=0.
//  2. Fill 16 entries (0x00..0x0F) -> full=1; write 0xAA -> overflow=1, count=16,
//     pops return 0x00..0x0F; 0xAA never appears; clr_stat -> overflow=0.
//  3. full, wr_en+rd_en same cycle with 0x55 -> rd returns 0x00, count stays 16,
//     overflow=0; 0x55 read out as 16th entry after draining.
//  4. DROP_ERR=1: write 0x10 err=3'b010, then 0x11 err=0 -> count=1, rd_data=0x11,
//     err_cnt=1; 260 error frames -> err_cnt=255.
//  5. Pointer wrap: 40 write/pop pairs with incrementing data -> every pop equals
//     write order, count never exceeds 1, empty toggles as expected.
//  6. Assert reset with count=5 mid-stream -> count=0, empty=1, overflow=0 at once;
//     after release, write 0x77 -> rd_data=0x77.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO behind the UART receiver.
// Holds {err,data} per frame, flags overflow, counts dropped error frames.
// Ports:
//  clk, reset          clock, async active-low reset
//  wr_en/wr_data/wr_err  frame strobe, byte, receiver error code
//  rd_en               pop head entry
//  rd_data/rd_err      head entry (0 while empty)
//  empty/full/count    fill state
//  overflow/err_cnt    sticky overflow, saturating drop count
//  clr_stat            clear overflow and err_cnt
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter bit DROP_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic [2:0]        wr_err,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic [2:0]        rd_err,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        err_cnt,
  input  logic              clr_stat
);

  localparam logic [ADDR_W:0] FULL_CNT =
    (ADDR_W+1)'(DEPTH);

  logic [10:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic drop;
  logic wr_ok;
  logic rd_ok;
  logic ovf_ev;
  logic drop_ev;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  assign drop = DROP_ERR && (wr_err != 3'd0);

  // A read in the same cycle frees the slot a full-FIFO write needs.
  assign wr_ok   = wr_en & ~drop & (~full | rd_en);
  assign rd_ok   = rd_en & ~empty;
  assign ovf_ev  = wr_en & ~drop & full & ~rd_en;
  assign drop_ev = wr_en & drop;

  // Storage is never cleared; pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= {wr_err, wr_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new event in the clearing cycle takes priority over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (ovf_ev)
        overflow <= 1'b1;
      else if (clr_stat)
        overflow <= 1'b0;

      if (drop_ev) begin
        if (clr_stat)
          err_cnt <= 8'd1;
        else if (err_cnt != 8'hFF)
          err_cnt <= err_cnt + 8'd1;
      end else if (clr_stat) begin
        err_cnt <= '0;
      end
    end
  end

  assign {rd_err, rd_data} = empty ? 11'd0 : mem[rd_ptr];

endmodule
